// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic MAC processing element.
// Holds the FSM state encoding, ERR bit positions and the default guard width.
// No logic; imported by the PE top and its sub-modules.
package pe_pkg;

  typedef enum logic {
    PE_IDLE  = 1'b0,
    PE_ACCUM = 1'b1
  } pe_state_e;

  // Bit positions inside the sticky ERR vector
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_FRAME   = 1;

  // Accumulator bits kept above the full-width product
  localparam int PE_GUARD_W_DEF = 8;

endpackage

// File: rtl/pe_multiplier.sv
// Combinational DATA_W x DATA_W multiplier, signed or unsigned per signed_mode_i.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the product is used.
module pe_multiplier #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                signed_mode_i,
  output logic [2*DATA_W-1:0] prod_o
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extend both operands to the product width; the low 2*DATA_W bits of the
  // extended product equal the exact signed or unsigned product.
  always_comb begin
    a_ext  = {{DATA_W{signed_mode_i & a_i[DATA_W-1]}}, a_i};
    b_ext  = {{DATA_W{signed_mode_i & b_i[DATA_W-1]}}, b_i};
    prod_o = a_ext * b_ext;
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC cell with framed accumulation and a one-entry result buffer.
// Latency: operands/tags forwarded in 1 cycle; Result valid 1 cycle after the LAST beat.
// Backpressure: RES_READY drains the buffer; a commit into a full, stalled buffer is dropped (ERR[0]).
// Build option: define PE_SATURATE_EN to clamp accumulation instead of wrapping.
module systolic_mac_pe
  import pe_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int GUARD_W = PE_GUARD_W_DEF,
  localparam int ACC_W   = 2*DATA_W + GUARD_W
) (
  input  logic              CLK,
  input  logic              ASYNC_RST,
  input  logic              SYNC_RST,
  input  logic              EN,
  input  logic              SIGNED_MODE,
  input  logic              IN_VALID,
  input  logic              IN_FIRST,
  input  logic              IN_LAST,
  input  logic [DATA_W-1:0] Input,
  input  logic [DATA_W-1:0] Weight,
  output logic [DATA_W-1:0] ToRight,
  output logic [DATA_W-1:0] ToDown,
  output logic              OUT_VALID,
  output logic              OUT_FIRST,
  output logic              OUT_LAST,
  output logic [ACC_W-1:0]  Result,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [1:0]        ERR
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    add_sum;

  pe_state_e           state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                commit;
  logic [ACC_W-1:0]    commit_sum;
  logic                frame_err;

  logic [ACC_W-1:0]    res_q, res_d;
  logic                res_vld_q, res_vld_d;
  logic [1:0]          err_q, err_d;

  logic [DATA_W-1:0]   right_q, down_q;
  logic                out_vld_q, out_first_q, out_last_q;

  pe_multiplier #(.DATA_W(DATA_W)) u_mul (
    .a_i           (Input),
    .b_i           (Weight),
    .signed_mode_i (SIGNED_MODE),
    .prod_o        (prod)
  );

  // Widen the product to accumulator width and add it to the running sum
  always_comb begin
    prod_ext = {{GUARD_W{SIGNED_MODE & prod[2*DATA_W-1]}}, prod};
`ifdef PE_SATURATE_EN
    begin : g_sat
      logic [ACC_W:0] add_wide;
      add_wide = {SIGNED_MODE & acc_q[ACC_W-1], acc_q} + {SIGNED_MODE & prod_ext[ACC_W-1], prod_ext};
      add_sum  = add_wide[ACC_W-1:0];
      if (SIGNED_MODE) begin
        // Overflow when the extra sign bit disagrees with the result sign
        if (add_wide[ACC_W] != add_wide[ACC_W-1])
          add_sum = add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else if (add_wide[ACC_W]) begin
        add_sum = '1;
      end
    end
`else
    add_sum = acc_q + prod_ext;
`endif
  end

  // Frame FSM: decides accumulator update, commit and framing errors per accepted beat
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    commit     = 1'b0;
    commit_sum = add_sum;
    frame_err  = 1'b0;
    if (EN && IN_VALID) begin
      case (state_q)
        PE_IDLE: begin
          if (IN_FIRST && IN_LAST) begin
            commit     = 1'b1;
            commit_sum = prod_ext;
          end else if (IN_FIRST) begin
            acc_d   = prod_ext;
            state_d = PE_ACCUM;
          end else begin
            frame_err = 1'b1;
          end
        end
        PE_ACCUM: begin
          if (IN_FIRST) begin
            // Unexpected restart: drop the partial sum and begin again
            acc_d     = prod_ext;
            frame_err = 1'b1;
          end else if (IN_LAST) begin
            commit     = 1'b1;
            commit_sum = add_sum;
            state_d    = PE_IDLE;
          end else begin
            acc_d = add_sum;
          end
        end
        default: state_d = PE_IDLE;
      endcase
    end
  end

  // Result buffer and sticky errors; draining does not depend on EN
  always_comb begin
    res_d     = res_q;
    res_vld_d = res_vld_q;
    err_d     = err_q;
    if (res_vld_q && RES_READY) res_vld_d = 1'b0;
    if (commit) begin
      if (!res_vld_q || RES_READY) begin
        res_d     = commit_sum;
        res_vld_d = 1'b1;
      end else begin
        err_d[ERR_OVERRUN] = 1'b1;
      end
    end
    if (frame_err) err_d[ERR_FRAME] = 1'b1;
  end

  // State, accumulator, result buffer and error registers
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q   <= PE_IDLE;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= '0;
    end else if (SYNC_RST) begin
      state_q   <= PE_IDLE;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
    end
  end

  // Forward operands and tags to the neighbours whenever the array advances
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      right_q     <= '0;
      down_q      <= '0;
      out_vld_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (SYNC_RST) begin
      right_q     <= '0;
      down_q      <= '0;
      out_vld_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (EN) begin
      right_q     <= Input;
      down_q      <= Weight;
      out_vld_q   <= IN_VALID;
      out_first_q <= IN_FIRST;
      out_last_q  <= IN_LAST;
    end
  end

  assign ToRight   = right_q;
  assign ToDown    = down_q;
  assign OUT_VALID = out_vld_q;
  assign OUT_FIRST = out_first_q;
  assign OUT_LAST  = out_last_q;
  assign Result    = res_q;
  assign RES_VALID = res_vld_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed self-checking bench for systolic_mac_pe with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
// Expected value of the long-accumulation test depends on PE_SATURATE_EN.
module tb_systolic_mac_pe;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;

  logic              CLK = 1'b0;
  logic              ASYNC_RST, SYNC_RST, EN, SIGNED_MODE;
  logic              IN_VALID, IN_FIRST, IN_LAST, RES_READY;
  logic [DATA_W-1:0] Input, Weight, ToRight, ToDown;
  logic              OUT_VALID, OUT_FIRST, OUT_LAST, RES_VALID;
  logic [ACC_W-1:0]  Result;
  logic [1:0]        ERR;

  int total = 0;
  int bad   = 0;

  systolic_mac_pe dut (
    .CLK         (CLK),
    .ASYNC_RST   (ASYNC_RST),
    .SYNC_RST    (SYNC_RST),
    .EN          (EN),
    .SIGNED_MODE (SIGNED_MODE),
    .IN_VALID    (IN_VALID),
    .IN_FIRST    (IN_FIRST),
    .IN_LAST     (IN_LAST),
    .Input       (Input),
    .Weight      (Weight),
    .ToRight     (ToRight),
    .ToDown      (ToDown),
    .OUT_VALID   (OUT_VALID),
    .OUT_FIRST   (OUT_FIRST),
    .OUT_LAST    (OUT_LAST),
    .Result      (Result),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic f, input logic l,
                      input logic [7:0] a, input logic [7:0] b);
    IN_VALID = v; IN_FIRST = f; IN_LAST = l; Input = a; Weight = b;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    ASYNC_RST = 1'b0;
    IN_VALID = 1'b0; IN_FIRST = 1'b0; IN_LAST = 1'b0;
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;
  endtask

  initial begin
    ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b1; SIGNED_MODE = 1'b0;
    IN_VALID = 1'b0; IN_FIRST = 1'b0; IN_LAST = 1'b0; RES_READY = 1'b1;
    Input = 8'h00; Weight = 8'h00;
    #2;
    chk("rst_result", Result, 0);
    chk("rst_resvld", RES_VALID, 0);
    chk("rst_err", ERR, 0);
    chk("rst_outvld", OUT_VALID, 0);
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;

    // 1: unsigned 3-beat frame 2*3 + 4*5 + 6*7 = 68
    beat(1, 1, 0, 8'd2, 8'd3);
    chk("t1_toright", ToRight, 2);
    chk("t1_todown", ToDown, 3);
    chk("t1_outfirst", OUT_FIRST, 1);
    chk("t1_outvld", OUT_VALID, 1);
    beat(1, 0, 0, 8'd4, 8'd5);
    chk("t1_vld_early", RES_VALID, 0);
    beat(1, 0, 1, 8'd6, 8'd7);
    chk("t1_result", Result, 68);
    chk("t1_resvld", RES_VALID, 1);
    chk("t1_outlast", OUT_LAST, 1);
    beat(0, 0, 0, 8'd0, 8'd0);
    chk("t1_drain", RES_VALID, 0);
    chk("t1_outvld0", OUT_VALID, 0);

    // 2: signed single beat -3 * 7 = -21, then a clean frame proves FSM is IDLE
    SIGNED_MODE = 1'b1;
    beat(1, 1, 1, 8'hFD, 8'd7);
    chk("t2_result", Result, 24'hFFFFEB);
    chk("t2_resvld", RES_VALID, 1);
    beat(1, 1, 0, 8'd1, 8'd1);
    beat(1, 0, 1, 8'd2, 8'd2);
    chk("t2_follow", Result, 5);
    chk("t2_err", ERR, 0);
    SIGNED_MODE = 1'b0;

    // 3: overrun with RES_READY low, then drain; then commit during handshake
    do_reset();
    RES_READY = 1'b0;
    beat(1, 1, 1, 8'd3, 8'd4);
    chk("t3_first", Result, 12);
    beat(1, 1, 1, 8'd5, 8'd5);
    chk("t3_kept", Result, 12);
    chk("t3_overrun", ERR, 2'b01);
    chk("t3_vldheld", RES_VALID, 1);
    RES_READY = 1'b1;
    beat(0, 0, 0, 8'd0, 8'd0);
    chk("t3_drain", RES_VALID, 0);
    beat(1, 1, 1, 8'd2, 8'd2);
    beat(1, 1, 1, 8'd3, 8'd3);
    chk("t3_swap_res", Result, 9);
    chk("t3_swap_vld", RES_VALID, 1);
    chk("t3_swap_err", ERR, 2'b01);

    // 4: framing errors: stray beat in IDLE, restart mid-frame
    do_reset();
    beat(1, 0, 0, 8'd9, 8'd9);
    chk("t4_stray_err", ERR, 2'b10);
    chk("t4_stray_vld", RES_VALID, 0);
    beat(1, 1, 0, 8'd1, 8'd2);
    beat(1, 1, 0, 8'd5, 8'd6);
    beat(1, 0, 1, 8'd1, 8'd1);
    chk("t4_restart", Result, 31);
    chk("t4_err", ERR, 2'b10);

    // 5: 300 x 255*255 unsigned
    do_reset();
    beat(1, 1, 0, 8'd255, 8'd255);
    for (int i = 0; i < 298; i++) beat(1, 0, 0, 8'd255, 8'd255);
    beat(1, 0, 1, 8'd255, 8'd255);
`ifdef PE_SATURATE_EN
    chk("t5_sat", Result, 24'hFFFFFF);
`else
    chk("t5_wrap", Result, 2730284);
`endif

    // 6: EN gaps and async reset mid-frame
    do_reset();
    RES_READY = 1'b0;
    beat(1, 1, 1, 8'd3, 8'd3);
    beat(1, 1, 0, 8'd2, 8'd2);
    EN = 1'b0;
    beat(1, 1, 1, 8'd9, 8'd9);
    chk("t6_frz_right", ToRight, 2);
    chk("t6_frz_vld", RES_VALID, 1);
    chk("t6_frz_res", Result, 9);
    RES_READY = 1'b1;
    beat(1, 1, 1, 8'd9, 8'd9);
    chk("t6_hs_noen", RES_VALID, 0);
    chk("t6_frz_down", ToDown, 2);
    EN = 1'b1; RES_READY = 1'b0;
    beat(1, 0, 1, 8'd1, 8'd1);
    chk("t6_acc_held", Result, 5);
    chk("t6_vld", RES_VALID, 1);
    beat(1, 1, 0, 8'd2, 8'd2);
    ASYNC_RST = 1'b0;
    #2;
    chk("t6_ar_right", ToRight, 0);
    chk("t6_ar_vld", RES_VALID, 0);
    chk("t6_ar_res", Result, 0);
    chk("t6_ar_outvld", OUT_VALID, 0);
    @(posedge CLK); #1;
    ASYNC_RST = 1'b1;
    beat(1, 0, 1, 8'd1, 8'd1);
    chk("t6_discard_err", ERR, 2'b10);
    chk("t6_discard_vld", RES_VALID, 0);
    SYNC_RST = 1'b1;
    beat(0, 0, 0, 8'd0, 8'd0);
    chk("t6_sr_err", ERR, 0);
    chk("t6_sr_right", ToRight, 0);
    SYNC_RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
